// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: producer side (in_*) and consumer
// side (out_*). The unit connects through the slave modport; the driver of
// the unit (decode stage or a bench) uses the master modport.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: widens an IN_W-bit immediate to OUT_W bits
// (modes: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH) and holds results in a
// 2-entry elastic buffer (head = output register, tail = skid register).
// Optional feature macro: IMM_EXT_BRANCH_EN. When undefined, mode 3 is
// treated as SIGN and the branch shift logic is not built.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_extend_pipe_if.slave   bus
);

  localparam int E = OUT_W - IN_W;

  generate
    if (IN_W < 3 || IN_W >= OUT_W) begin : g_bad_params
      $fatal(1, "imm_extend_pipe: need 3 <= IN_W < OUT_W");
    end
  endgenerate

  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] tail_q, tail_d;
  logic [OUT_W-1:0] ext_val;
  logic             accept, pop;

  // Extension of the incoming immediate, selected by mode
  always_comb begin
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    sign_ext = {{E{bus.in_imm[IN_W-1]}}, bus.in_imm};
    zero_ext = {{E{1'b0}}, bus.in_imm};
    ext_val  = sign_ext;
    case (bus.in_mode)
      2'd0: ext_val = sign_ext;
      2'd1: ext_val = zero_ext;
      2'd2: ext_val = zero_ext << E;
`ifdef IMM_EXT_BRANCH_EN
      2'd3: ext_val = sign_ext << 2;
`else
      2'd3: ext_val = sign_ext;
`endif
      default: ext_val = sign_ext;
    endcase
  end

  // in_ready is gated by rst_n so nothing is taken while reset is held
  assign bus.in_ready  = rst_n && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = head_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  // Buffer next-state: strict FIFO, tail slides into head on pop when full
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (accept) begin
          head_d  = ext_val;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (accept && pop) begin
          head_d = ext_val;
        end else if (accept) begin
          tail_d  = ext_val;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // Buffer state registers; reset clears contents and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed mode table, backpressure, streaming,
// async reset, randomized traffic against a queue model, and an 8->16 instance.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
  imm_extend_pipe_if #(.IN_W(8),  .OUT_W(16)) bus8 ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

`ifdef IMM_EXT_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  imm;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec8_t;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from plain arithmetic on the numeric value
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
    logic [31:0] s;
    s = (imm >= 16'h8000) ? (32'(imm) + 32'hFFFF0000) : 32'(imm);
    case (m)
      2'd0: return s;
      2'd1: return 32'(imm);
      2'd2: return 32'(imm) * 32'd65536;
      default: return BR_EN ? s * 32'd4 : s;
    endcase
  endfunction

  task automatic chk_state(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(q.size() != 2));
    if (q.size() != 0) check({tag, "_out_data"}, bus.out_data, q[0]);
  endtask

  // One clock: model decides accept/pop from pre-edge state, then compares
  task automatic tick(input string tag);
    bit acc, pp;
    logic [31:0] v;
    acc = bus.in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && bus.out_ready;
    v   = ref_ext(bus.in_imm, bus.in_mode);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(v);
    #1;
    chk_state(tag);
  endtask

  task automatic drive(input bit v, input logic [15:0] imm, input logic [1:0] m, input bit rdy);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_mode   = m;
    bus.out_ready = rdy;
  endtask

  vec_t  tbl[8];
  vec8_t tbl8[4];

  initial begin
    tbl[0] = '{16'h8001, 2'd0, 32'hFFFF8001};
    tbl[1] = '{16'h8001, 2'd1, 32'h00008001};
    tbl[2] = '{16'h8001, 2'd2, 32'h80010000};
    tbl[3] = '{16'h8001, 2'd3, BR_EN ? 32'hFFFE0004 : 32'hFFFF8001};
    tbl[4] = '{16'h7FFF, 2'd3, BR_EN ? 32'h0001FFFC : 32'h00007FFF};
    tbl[5] = '{16'h0000, 2'd0, 32'h00000000};
    tbl[6] = '{16'hFFFF, 2'd2, 32'hFFFF0000};
    tbl[7] = '{16'h8000, 2'd3, BR_EN ? 32'hFFFE0000 : 32'hFFFF8000};
    tbl8[0] = '{8'hA5, 2'd2, 16'hA500};
    tbl8[1] = '{8'hA5, 2'd0, 16'hFFA5};
    tbl8[2] = '{8'hA5, 2'd1, 16'h00A5};
    tbl8[3] = '{8'hA5, 2'd3, BR_EN ? 16'hFE94 : 16'hFFA5};

    drive(1'b0, 16'h0, 2'd0, 1'b0);
    bus8.in_valid = 1'b0; bus8.in_imm = 8'h0; bus8.in_mode = 2'd0; bus8.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Mode table: result visible the cycle after acceptance
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].imm, tbl[i].mode, 1'b1);
      tick("tbl");
      check($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].exp);
      check($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
      drive(1'b0, 16'h0, 2'd0, 1'b1);
      tick("tbl_drain");
    end

    // Backpressure: A, B absorbed, C held, then drained in order
    drive(1'b1, 16'h000A, 2'd1, 1'b0); tick("bp_a");
    drive(1'b1, 16'h000B, 2'd1, 1'b0); tick("bp_b");
    check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h000C, 2'd1, 1'b0); tick("bp_c_held");
    check("bp_head_a", bus.out_data, 32'h0000000A);
    drive(1'b1, 16'h000C, 2'd1, 1'b1); tick("bp_pop_a");
    check("bp_head_b", bus.out_data, 32'h0000000B);
    tick("bp_acc_c");
    check("bp_head_c", bus.out_data, 32'h0000000C);
    drive(1'b0, 16'h0, 2'd0, 1'b1); tick("bp_drain");
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming at count==1: one in, one out every cycle
    drive(1'b1, 16'h0100, 2'd1, 1'b1); tick("st_prime");
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 2'd1, 1'b1);
      tick("st");
      check("st_data", bus.out_data, 32'(16'h0100 + i));
      check("st_in_ready", 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, 16'h0, 2'd0, 1'b1); tick("st_drain");

    // Asynchronous reset with the buffer full
    drive(1'b1, 16'h1111, 2'd1, 1'b0); tick("mr_a");
    drive(1'b1, 16'h2222, 2'd1, 1'b0); tick("mr_b");
    drive(1'b0, 16'h0, 2'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check("mr_out_data", bus.out_data, 32'd0);
    check("mr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_rel_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'h3333, 2'd1, 1'b0); tick("mr_new");
    check("mr_new_data", bus.out_data, 32'h00003333);
    drive(1'b0, 16'h0, 2'd0, 1'b1); tick("mr_drain");

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 70), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 99) < 60));
      tick("rnd");
    end
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    tick("rnd_drain0"); tick("rnd_drain1"); tick("rnd_drain2");

    // Narrow instance: IN_W=8, OUT_W=16
    foreach (tbl8[i]) begin
      bus8.in_valid = 1'b1; bus8.in_imm = tbl8[i].imm; bus8.in_mode = tbl8[i].mode;
      @(posedge clk); #1;
      check($sformatf("w8_%0d_valid", i), 32'(bus8.out_valid), 32'd1);
      check($sformatf("w8_%0d_data", i), 32'(bus8.out_data), 32'(tbl8[i].exp));
      bus8.in_valid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("w8_%0d_empty", i), 32'(bus8.out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
